id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between decode and execute for the RISC-V core, with built-in load-use hazard detection. Each cycle it captures the control bundle produced by the control unit, plus operands, immediate, register indices and PC. On a load-use hazard it tells fetch/decode to freeze and inserts a bubble into execute. On a branch/jump flush from execute it squashes the decoded instruction.

## Interface
- DATA_WIDTH, 32, width of operand, immediate and PC fields
- REG_ADDR_WIDTH, 5, register index width
- CNT_WIDTH, 16, width of bubble counter
- i_clk  in  1  core clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- iv_OpCode  in  7  opcode of decode-stage instruction
- iv_Ctrl  in  14  control bundle, MSB→LSB {ForceJump, Branch, Jump_PC, JumpRD, Mem_To_Reg, Mem_Write, Mem_Read, ALUsrc, LUIsrc, Reg_Write, AluOp[3:0]}
- i_Valid  in  1  decode stage holds a real instruction
- iv_Rs1Data, iv_Rs2Data, iv_Imm, iv_PC  in  DATA_WIDTH  decode-stage values
- iv_Rs1, iv_Rs2, iv_Rd  in  REG_ADDR_WIDTH  decode-stage register indices
- iv_Funct3  in  3, i_Funct7b5  in  1  ALU sub-op fields
- i_Flush  in  1  execute resolved a taken branch/jump; squash decode
- i_Hold  in  1  global freeze (memory wait)
- o_Stall  out  1  freeze PC and IF/ID this cycle (combinational)
- ov_Ctrl  out  14, o_Valid  out  1, ov_Rs1Data/ov_Rs2Data/ov_Imm/ov_PC  out  DATA_WIDTH, ov_Rs1/ov_Rs2/ov_Rd  out  REG_ADDR_WIDTH, ov_Funct3  out  3, o_Funct7b5  out  1  registered execute-stage copies
- ov_BubbleCount  out  CNT_WIDTH  saturating count of inserted bubbles

## Operation
- rs1 is used by every opcode except LUI 0110111, AUIPC 0010111 and JAL 1101111.
- rs2 is used only by R 0110011, S 0100011 and B 1100011.
- Hazard = o_Valid & ov_Ctrl[Mem_Read] & (ov_Rd≠0) & i_Valid & ((rs1 used & iv_Rs1==ov_Rd) | (rs2 used & iv_Rs2==ov_Rd)).
- o_Stall = Hazard & ~i_Flush. It is independent of i_Hold.
- Bubble: ov_Ctrl=0 and o_Valid=0. Data, index and PC fields are don't-care; the implementation zeroes them.
- Register update priority per clock edge:
  1. Flush → bubble.
  2. Hold → all registers keep their value.
  3. Hazard → bubble.
  4. Otherwise → load all inputs; o_Valid=i_Valid. When i_Valid=0, ov_Ctrl is loaded as 0.
- ov_BubbleCount increments by 1 on every edge that writes a bubble because of flush or hazard. It does not increment on hold, and saturates at all-ones.
- x0 destination never raises a hazard. Back-to-back load followed by a dependent instruction stalls exactly one cycle: the bubble clears the hazard on the following cycle.

## Timing
- Reset (async assert, sync release on i_clk): every registered output and ov_BubbleCount go to 0; o_Valid=0. o_Stall then evaluates to 0.
- Latency: decode inputs appear on outputs 1 cycle after a non-stalled, non-held edge.
- o_Stall is combinational from current inputs and registered outputs, and must settle within the same cycle.
- Flush and hazard in the same cycle: bubble, o_Stall=0, count +1.
- Flush and hold in the same cycle: flush wins.
- Reset mid-stall: outputs clear immediately (asynchronously); no residual stall.

## Structure
- Shared package (riscv_pkg): opcode constants (U, J, B, Ijalr, I_l, S, I, R, AUIPC), iv_Ctrl bit-index localparams, CTRL_W=14.
- Sub-module hazard_detect (combinational): inputs are opcode, rs1, rs2, i_Valid and the execute-stage rd/Mem_Read/Valid; output is Hazard.
- Top level contains the register bank, the priority mux and the counter.

## Test plan
- Reset asserted mid-stream → all outputs 0 asynchronously, ov_BubbleCount=0; first loaded instruction appears 1 cycle after release.
- lw x5 then add x6,x5,x1 → o_Stall=1 for one cycle, execute shows a bubble (o_Valid=0, ov_Ctrl=0), add enters the next cycle, count=1.
- lw x0 then add x6,x0,x1 → no stall; lw x5 then lui x5 → no stall (rs1 unused); lw x5 then sw x7,0(x5)/sw x5,0(x7) → stall in both cases.
- i_Flush with a hazard pending → bubble, o_Stall=0, count +1; i_Flush with i_Hold → bubble.
- i_Hold for 3 cycles with changing inputs → outputs frozen, count unchanged; release → next edge loads current inputs.
- Force 65540 flushes → ov_BubbleCount saturates at 16'hFFFF.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V decode definitions: opcode encodings, control-bundle bit positions
// and operand-usage helpers used by the decode/execute pipeline.
package riscv_pkg;

  localparam int unsigned CTRL_W   = 14;
  localparam int unsigned OPCODE_W = 7;

  typedef enum logic [OPCODE_W-1:0] {
    OP_U     = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_J     = 7'b1101111,
    OP_B     = 7'b1100011,
    OP_IJALR = 7'b1100111,
    OP_I_L   = 7'b0000011,
    OP_S     = 7'b0100011,
    OP_I     = 7'b0010011,
    OP_R     = 7'b0110011
  } opcode_e;

  // Bit positions inside the control bundle, MSB first
  localparam int unsigned CTRL_FORCE_JUMP = 13;
  localparam int unsigned CTRL_BRANCH     = 12;
  localparam int unsigned CTRL_JUMP_PC    = 11;
  localparam int unsigned CTRL_JUMP_RD    = 10;
  localparam int unsigned CTRL_MEM_TO_REG = 9;
  localparam int unsigned CTRL_MEM_WRITE  = 8;
  localparam int unsigned CTRL_MEM_READ   = 7;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_LUI_SRC    = 5;
  localparam int unsigned CTRL_REG_WRITE  = 4;
  localparam int unsigned CTRL_ALUOP_MSB  = 3;
  localparam int unsigned CTRL_ALUOP_LSB  = 0;

  function automatic logic uses_rs1(input logic [OPCODE_W-1:0] op);
    return !((op == OP_U) || (op == OP_AUIPC) || (op == OP_J));
  endfunction

  function automatic logic uses_rs2(input logic [OPCODE_W-1:0] op);
    return (op == OP_R) || (op == OP_S) || (op == OP_B);
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Decode-to-execute bundle: decode-stage inputs, control strobes and the
// registered execute-stage copies with the stall and bubble-count feedback.
interface id_ex_stage_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
);
  import riscv_pkg::*;

  logic [OPCODE_W-1:0]       iv_OpCode;
  logic [CTRL_W-1:0]         iv_Ctrl;
  logic                      i_Valid;
  logic [DATA_WIDTH-1:0]     iv_Rs1Data;
  logic [DATA_WIDTH-1:0]     iv_Rs2Data;
  logic [DATA_WIDTH-1:0]     iv_Imm;
  logic [DATA_WIDTH-1:0]     iv_PC;
  logic [REG_ADDR_WIDTH-1:0] iv_Rs1;
  logic [REG_ADDR_WIDTH-1:0] iv_Rs2;
  logic [REG_ADDR_WIDTH-1:0] iv_Rd;
  logic [2:0]                iv_Funct3;
  logic                      i_Funct7b5;
  logic                      i_Flush;
  logic                      i_Hold;

  logic                      o_Stall;
  logic [CTRL_W-1:0]         ov_Ctrl;
  logic                      o_Valid;
  logic [DATA_WIDTH-1:0]     ov_Rs1Data;
  logic [DATA_WIDTH-1:0]     ov_Rs2Data;
  logic [DATA_WIDTH-1:0]     ov_Imm;
  logic [DATA_WIDTH-1:0]     ov_PC;
  logic [REG_ADDR_WIDTH-1:0] ov_Rs1;
  logic [REG_ADDR_WIDTH-1:0] ov_Rs2;
  logic [REG_ADDR_WIDTH-1:0] ov_Rd;
  logic [2:0]                ov_Funct3;
  logic                      o_Funct7b5;
  logic [CNT_WIDTH-1:0]      ov_BubbleCount;

  modport master (
    output iv_OpCode, iv_Ctrl, i_Valid, iv_Rs1Data, iv_Rs2Data, iv_Imm, iv_PC,
           iv_Rs1, iv_Rs2, iv_Rd, iv_Funct3, i_Funct7b5, i_Flush, i_Hold,
    input  o_Stall, ov_Ctrl, o_Valid, ov_Rs1Data, ov_Rs2Data, ov_Imm, ov_PC,
           ov_Rs1, ov_Rs2, ov_Rd, ov_Funct3, o_Funct7b5, ov_BubbleCount
  );

  modport slave (
    input  iv_OpCode, iv_Ctrl, i_Valid, iv_Rs1Data, iv_Rs2Data, iv_Imm, iv_PC,
           iv_Rs1, iv_Rs2, iv_Rd, iv_Funct3, i_Funct7b5, i_Flush, i_Hold,
    output o_Stall, ov_Ctrl, o_Valid, ov_Rs1Data, ov_Rs2Data, ov_Imm, ov_PC,
           ov_Rs1, ov_Rs2, ov_Rd, ov_Funct3, o_Funct7b5, ov_BubbleCount
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a valid load in execute whose rd (non-x0) matches a
// source register actually read by the valid instruction sitting in decode.
module hazard_detect
  import riscv_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic [OPCODE_W-1:0]       iv_OpCode,
  input  logic [REG_ADDR_WIDTH-1:0] iv_Rs1,
  input  logic [REG_ADDR_WIDTH-1:0] iv_Rs2,
  input  logic                      i_Valid,
  input  logic [REG_ADDR_WIDTH-1:0] iv_ExRd,
  input  logic                      i_ExMemRead,
  input  logic                      i_ExValid,
  output logic                      o_Hazard
);

  logic load_in_ex;
  logic rs1_hit;
  logic rs2_hit;

  assign load_in_ex = i_ExValid & i_ExMemRead & (iv_ExRd != '0);
  assign rs1_hit    = uses_rs1(iv_OpCode) & (iv_Rs1 == iv_ExRd);
  assign rs2_hit    = uses_rs2(iv_OpCode) & (iv_Rs2 == iv_ExRd);
  assign o_Hazard   = load_in_ex & i_Valid & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush squash, global hold and a
// saturating count of inserted bubbles.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  id_ex_stage_if.slave bus
);

  logic                      hazard;
  logic                      bubble;
  logic [CTRL_W-1:0]         ctrl_q,  ctrl_d;
  logic                      valid_q, valid_d;
  logic [DATA_WIDTH-1:0]     rs1d_q,  rs1d_d;
  logic [DATA_WIDTH-1:0]     rs2d_q,  rs2d_d;
  logic [DATA_WIDTH-1:0]     imm_q,   imm_d;
  logic [DATA_WIDTH-1:0]     pc_q,    pc_d;
  logic [REG_ADDR_WIDTH-1:0] rs1_q,   rs1_d;
  logic [REG_ADDR_WIDTH-1:0] rs2_q,   rs2_d;
  logic [REG_ADDR_WIDTH-1:0] rd_q,    rd_d;
  logic [2:0]                f3_q,    f3_d;
  logic                      f7_q,    f7_d;
  logic [CNT_WIDTH-1:0]      cnt_q,   cnt_d;

  hazard_detect #(.REG_ADDR_WIDTH(REG_ADDR_WIDTH)) u_hazard_detect (
    .iv_OpCode   (bus.iv_OpCode),
    .iv_Rs1      (bus.iv_Rs1),
    .iv_Rs2      (bus.iv_Rs2),
    .i_Valid     (bus.i_Valid),
    .iv_ExRd     (rd_q),
    .i_ExMemRead (ctrl_q[CTRL_MEM_READ]),
    .i_ExValid   (valid_q),
    .o_Hazard    (hazard)
  );

  // A flush already kills the decode instruction, so freezing fetch would be wrong
  assign bus.o_Stall = hazard & ~bus.i_Flush;

  // Flush outranks hold; a hazard only bubbles when the pipe is not held
  assign bubble = bus.i_Flush | (~bus.i_Hold & hazard);

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    cnt_d   = cnt_q;
    if (bubble) begin
      ctrl_d  = '0;
      valid_d = 1'b0;
      rs1d_d  = '0;
      rs2d_d  = '0;
      imm_d   = '0;
      pc_d    = '0;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      f3_d    = '0;
      f7_d    = 1'b0;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (!bus.i_Hold) begin
      ctrl_d  = bus.i_Valid ? bus.iv_Ctrl : '0;
      valid_d = bus.i_Valid;
      rs1d_d  = bus.iv_Rs1Data;
      rs2d_d  = bus.iv_Rs2Data;
      imm_d   = bus.iv_Imm;
      pc_d    = bus.iv_PC;
      rs1_d   = bus.iv_Rs1;
      rs2_d   = bus.iv_Rs2;
      rd_d    = bus.iv_Rd;
      f3_d    = bus.iv_Funct3;
      f7_d    = bus.i_Funct7b5;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_q  <= '0;
      valid_q <= 1'b0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      f3_q    <= '0;
      f7_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ov_Ctrl        = ctrl_q;
  assign bus.o_Valid        = valid_q;
  assign bus.ov_Rs1Data     = rs1d_q;
  assign bus.ov_Rs2Data     = rs2d_q;
  assign bus.ov_Imm         = imm_q;
  assign bus.ov_PC          = pc_q;
  assign bus.ov_Rs1         = rs1_q;
  assign bus.ov_Rs2         = rs2_q;
  assign bus.ov_Rd          = rd_q;
  assign bus.ov_Funct3      = f3_q;
  assign bus.o_Funct7b5     = f7_q;
  assign bus.ov_BubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a behavioural model of
// the execute-stage register contents and bubble counter.
module tb_id_ex_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 16;

  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] OPIMM = 7'b0010011;
  localparam logic [6:0] OPR   = 7'b0110011;

  localparam logic [13:0] C_LW  = 14'h02D0;
  localparam logic [13:0] C_ADD = 14'h0010;
  localparam logic [13:0] C_SW  = 14'h0140;
  localparam logic [13:0] C_LUI = 14'h0030;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [6:0] op_list [9] = '{LUI, AUIPC, JAL, BR, JALR, LOAD, STORE, OPIMM, OPR};

  // Expected execute-stage contents
  logic        e_valid;
  logic [13:0] e_ctrl;
  logic [31:0] e_rs1d, e_rs2d, e_imm, e_pc;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [2:0]  e_f3;
  logic        e_f7;
  logic [15:0] e_cnt;

  id_ex_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic bit reads_rs1(input logic [6:0] op);
    return !(op inside {LUI, AUIPC, JAL});
  endfunction

  function automatic bit reads_rs2(input logic [6:0] op);
    return op inside {OPR, STORE, BR};
  endfunction

  function automatic bit exp_hazard();
    return e_valid && e_ctrl[7] && (e_rd != 5'd0) && bus.i_Valid &&
           ((reads_rs1(bus.iv_OpCode) && bus.iv_Rs1 == e_rd) ||
            (reads_rs2(bus.iv_OpCode) && bus.iv_Rs2 == e_rd));
  endfunction

  task automatic model_reset();
    e_valid = 1'b0; e_ctrl = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0; e_pc = '0;
    e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_f3 = '0; e_f7 = 1'b0; e_cnt = '0;
  endtask

  task automatic model_edge();
    bit hz;
    hz = exp_hazard();
    if (bus.i_Flush || (!bus.i_Hold && hz)) begin
      e_valid = 1'b0; e_ctrl = '0; e_rs1d = '0; e_rs2d = '0; e_imm = '0; e_pc = '0;
      e_rs1 = '0; e_rs2 = '0; e_rd = '0; e_f3 = '0; e_f7 = 1'b0;
      if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
    end else if (!bus.i_Hold) begin
      e_valid = bus.i_Valid;
      e_ctrl  = bus.i_Valid ? bus.iv_Ctrl : 14'd0;
      e_rs1d = bus.iv_Rs1Data; e_rs2d = bus.iv_Rs2Data; e_imm = bus.iv_Imm; e_pc = bus.iv_PC;
      e_rs1 = bus.iv_Rs1; e_rs2 = bus.iv_Rs2; e_rd = bus.iv_Rd;
      e_f3 = bus.iv_Funct3; e_f7 = bus.i_Funct7b5;
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 64'(bus.o_Valid), 64'(e_valid));
    chk({tag, ".ctrl"},  64'(bus.ov_Ctrl), 64'(e_ctrl));
    chk({tag, ".count"}, 64'(bus.ov_BubbleCount), 64'(e_cnt));
    chk({tag, ".ops"},   {bus.ov_Rs1Data, bus.ov_Rs2Data}, {e_rs1d, e_rs2d});
    chk({tag, ".immpc"}, {bus.ov_Imm, bus.ov_PC}, {e_imm, e_pc});
    chk({tag, ".idx"},   64'({bus.ov_Rs1, bus.ov_Rs2, bus.ov_Rd, bus.ov_Funct3, bus.o_Funct7b5}),
                         64'({e_rs1, e_rs2, e_rd, e_f3, e_f7}));
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [13:0] ctrl, input logic valid,
                       input logic flush, input logic hold);
    bus.iv_OpCode  = op;
    bus.iv_Ctrl    = ctrl;
    bus.i_Valid    = valid;
    bus.iv_Rs1     = rs1;
    bus.iv_Rs2     = rs2;
    bus.iv_Rd      = rd;
    bus.iv_Rs1Data = $urandom;
    bus.iv_Rs2Data = $urandom;
    bus.iv_Imm     = $urandom;
    bus.iv_PC      = $urandom;
    bus.iv_Funct3  = 3'($urandom_range(7));
    bus.i_Funct7b5 = 1'($urandom_range(1));
    bus.i_Flush    = flush;
    bus.i_Hold     = hold;
  endtask

  // Check the combinational stall, take one clock edge, then check the registers
  task automatic step(input string tag);
    #1;
    chk({tag, ".stall"}, 64'(bus.o_Stall), 64'(exp_hazard() && !bus.i_Flush));
    @(posedge clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [6:0]  rop;
    logic [13:0] rctrl;

    drive(OPIMM, 5'd1, 5'd2, 5'd3, C_ADD, 1'b1, 1'b0, 1'b0);
    model_reset();
    #2;
    check_outputs("reset");
    chk("reset.stall", 64'(bus.o_Stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(OPIMM, 5'd1, 5'd2, 5'd3, C_ADD, 1'b1, 1'b0, 1'b0);
    step("first");
    chk("first.rd", 64'(bus.ov_Rd), 64'd3);

    // lw x5 ; add x6,x5,x1
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("lu.lw");
    drive(OPR, 5'd5, 5'd1, 5'd6, C_ADD, 1'b1, 1'b0, 1'b0);  step("lu.stall");
    chk("lu.bubble_valid", 64'(bus.o_Valid), 64'd0);
    chk("lu.bubble_ctrl", 64'(bus.ov_Ctrl), 64'd0);
    chk("lu.count", 64'(bus.ov_BubbleCount), 64'd1);
    step("lu.enter");
    chk("lu.add_rd", 64'(bus.ov_Rd), 64'd6);
    chk("lu.add_valid", 64'(bus.o_Valid), 64'd1);

    // lw x0 ; add x6,x0,x1
    drive(LOAD, 5'd2, 5'd0, 5'd0, C_LW, 1'b1, 1'b0, 1'b0);  step("x0.lw");
    drive(OPR, 5'd0, 5'd1, 5'd6, C_ADD, 1'b1, 1'b0, 1'b0);  step("x0.add");
    chk("x0.nostall_valid", 64'(bus.o_Valid), 64'd1);

    // lw x5 ; lui x5
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("lui.lw");
    drive(LUI, 5'd5, 5'd5, 5'd5, C_LUI, 1'b1, 1'b0, 1'b0);  step("lui.go");

    // lw x5 ; sw x7,0(x5)  then  lw x5 ; sw x5,0(x7)
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("sw1.lw");
    drive(STORE, 5'd5, 5'd7, 5'd0, C_SW, 1'b1, 1'b0, 1'b0); step("sw1.stall");
    step("sw1.enter");
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("sw2.lw");
    drive(STORE, 5'd7, 5'd5, 5'd0, C_SW, 1'b1, 1'b0, 1'b0); step("sw2.stall");
    step("sw2.enter");

    // Flush while a hazard is pending, then flush together with hold
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("fh.lw");
    drive(OPR, 5'd5, 5'd1, 5'd6, C_ADD, 1'b1, 1'b1, 1'b0);  step("fh.flush");
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("fhold.lw");
    drive(OPIMM, 5'd1, 5'd1, 5'd9, C_ADD, 1'b1, 1'b1, 1'b1); step("fhold.flush");
    chk("fhold.valid", 64'(bus.o_Valid), 64'd0);

    // Hold for three cycles with changing inputs, then release
    drive(OPIMM, 5'd3, 5'd4, 5'd8, C_ADD, 1'b1, 1'b0, 1'b0); step("hold.load");
    repeat (3) begin
      drive(op_list[$urandom_range(8)], 5'($urandom), 5'($urandom), 5'($urandom),
            14'($urandom), 1'b1, 1'b0, 1'b1);
      step("hold.frozen");
    end
    drive(OPR, 5'd1, 5'd2, 5'd10, C_ADD, 1'b1, 1'b0, 1'b0); step("hold.release");
    chk("hold.release_rd", 64'(bus.ov_Rd), 64'd10);

    // Hazard under hold keeps stalling without bubbling
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("hh.lw");
    drive(OPR, 5'd5, 5'd1, 5'd6, C_ADD, 1'b1, 1'b0, 1'b1);  step("hh.hold1");
    step("hh.hold2");
    drive(OPR, 5'd5, 5'd1, 5'd6, C_ADD, 1'b1, 1'b0, 1'b0);  step("hh.bubble");
    step("hh.enter");

    // Invalid decode slot loads with a cleared control bundle
    drive(OPR, 5'd1, 5'd2, 5'd3, C_ADD, 1'b0, 1'b0, 1'b0);  step("inv");

    // Asynchronous reset in the middle of a stall
    drive(LOAD, 5'd2, 5'd0, 5'd5, C_LW, 1'b1, 1'b0, 1'b0);  step("rst.lw");
    drive(OPR, 5'd5, 5'd1, 5'd6, C_ADD, 1'b1, 1'b0, 1'b0);
    #1;
    chk("rst.pre_stall", 64'(bus.o_Stall), 64'd1);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst.async");
    chk("rst.stall", 64'(bus.o_Stall), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(OPIMM, 5'd4, 5'd4, 5'd12, C_ADD, 1'b1, 1'b0, 1'b0); step("rst.first");
    chk("rst.first_rd", 64'(bus.ov_Rd), 64'd12);

    // Randomized traffic with small register indices to provoke hazards
    repeat (600) begin
      rop = ($urandom_range(15) == 0) ? 7'($urandom) : op_list[$urandom_range(8)];
      rctrl = 14'($urandom);
      if ($urandom_range(2) == 0) rctrl[7] = 1'b1;
      drive(rop, 5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)), rctrl,
            1'($urandom_range(7) != 0), 1'($urandom_range(9) == 0), 1'($urandom_range(7) == 0));
      step("rand");
    end

    // Saturate the bubble counter
    repeat (65540) begin
      drive(OPIMM, 5'd0, 5'd0, 5'd0, C_ADD, 1'b1, 1'b1, 1'b0);
      @(posedge clk);
      model_edge();
      #1;
    end
    check_outputs("sat");
    chk("sat.count", 64'(bus.ov_BubbleCount), 64'hFFFF);
    step("sat.more");
    chk("sat.hold_at_max", 64'(bus.ov_BubbleCount), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
